// File: rtl/nn_pkg.sv
// nn_pkg: output-layer dimensions and scanner state type shared with the network.
package nn_pkg;
  localparam int N_CLASSES = 10;
  localparam int SCORE_W = 8;
  typedef logic [SCORE_W-1:0] score_t;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} scan_state_t;
endpackage

// File: rtl/argmax_step.sv
// argmax_step: combinational top-2 update for one score; strict compares keep the lowest index on ties.
module argmax_step #(
  parameter int SCORE_W = 8,
  parameter int IDX_W = 4
) (
  input  logic [SCORE_W-1:0] best,
  input  logic [SCORE_W-1:0] second,
  input  logic [IDX_W-1:0]   best_idx,
  input  logic [SCORE_W-1:0] score,
  input  logic [IDX_W-1:0]   index,
  input  logic               first,
  output logic [SCORE_W-1:0] best_nxt,
  output logic [SCORE_W-1:0] second_nxt,
  output logic [IDX_W-1:0]   best_idx_nxt
);
  logic win;
  always_comb begin
    win = first || score > best;
    best_nxt = win ? score : best;
    best_idx_nxt = win ? index : best_idx;
    second_nxt = first ? '0 : score > best ? best : score > second ? score : second;
  end
endmodule

// File: rtl/output_argmax_scanner.sv
// output_argmax_scanner: snapshots the class scores and scans one per cycle for winner, margin and tie.
module output_argmax_scanner
  import nn_pkg::*;
#(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int SCORE_W = nn_pkg::SCORE_W,
  localparam int IDX_W = N_CLASSES > 1 ? $clog2(N_CLASSES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] scores [N_CLASSES],
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [IDX_W-1:0]   class_idx,
  output logic [SCORE_W-1:0] top_score,
  output logic [SCORE_W-1:0] margin,
  output logic               tie
);
  scan_state_t state;
  logic [SCORE_W-1:0] snap [N_CLASSES];
  logic [IDX_W-1:0] cnt, best_idx, nb_idx;
  logic [SCORE_W-1:0] best, second, nb, ns;
  logic last;
  assign last = cnt == IDX_W'(N_CLASSES - 1);
  argmax_step #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_step (
    .best(best), .second(second), .best_idx(best_idx),
    .score(snap[cnt]), .index(cnt), .first(cnt == '0),
    .best_nxt(nb), .second_nxt(ns), .best_idx_nxt(nb_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      result_valid <= 1'b0;
      class_idx <= '0;
      top_score <= '0;
      margin <= '0;
      tie <= 1'b0;
      cnt <= '0;
      best <= '0;
      second <= '0;
      best_idx <= '0;
      for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap <= scores;
          cnt <= '0;
          best <= '0;
          second <= '0;
          best_idx <= '0;
          busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          best <= nb;
          second <= ns;
          best_idx <= nb_idx;
          if (last) begin
            class_idx <= nb_idx;
            top_score <= nb;
            margin <= nb - ns;
            tie <= N_CLASSES > 1 && nb == ns;
            result_valid <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: if (result_ready) begin
          result_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_argmax_scanner.sv
// tb_output_argmax_scanner: vector table plus corner sequences, scored through an expected-result queue.
module tb_output_argmax_scanner;
  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] top;
    logic [7:0] mar;
    logic       tie;
  } res_t;
  typedef struct packed {
    logic [0:9][7:0] s;
    res_t            r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic result_ready = 1'b1;
  logic [7:0] scores [10];
  logic busy, result_valid, tie;
  logic [3:0] class_idx;
  logic [7:0] top_score, margin;

  logic start1 = 1'b0;
  logic [7:0] scores1 [1];
  logic busy1, result_valid1, tie1;
  logic [0:0] class_idx1;
  logic [7:0] top_score1, margin1;

  int checks = 0;
  int errors = 0;
  res_t exp_q[$];
  logic prev_v = 1'b0;

  output_argmax_scanner dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .class_idx(class_idx),
    .top_score(top_score), .margin(margin), .tie(tie)
  );

  output_argmax_scanner #(.N_CLASSES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .scores(scores1), .busy(busy1),
    .result_valid(result_valid1), .result_ready(1'b1), .class_idx(class_idx1),
    .top_score(top_score1), .margin(margin1), .tie(tie1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Reference: first index of the maximum, second-best is the max of all other entries.
  function automatic res_t model(input logic [0:9][7:0] s);
    res_t r;
    int bi = 0;
    int sec = 0;
    for (int i = 1; i < 10; i++) if (s[i] > s[bi]) bi = i;
    for (int i = 0; i < 10; i++) if (i != bi && int'(s[i]) > sec) sec = int'(s[i]);
    r.idx = 4'(bi);
    r.top = s[bi];
    r.mar = 8'(int'(s[bi]) - sec);
    r.tie = r.mar == 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && result_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got class %0d expected no result", class_idx);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("class_idx", int'(class_idx), int'(e.idx));
        chk("top_score", int'(top_score), int'(e.top));
        chk("margin", int'(margin), int'(e.mar));
        chk("tie", int'(tie), int'(e.tie));
      end
    end
    prev_v <= result_valid && !rst;
  end

  task automatic drive(input logic [0:9][7:0] s);
    for (int i = 0; i < 10; i++) scores[i] = s[i];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 41;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_full(input vec_t v);
    int lat;
    exp_q.push_back(v.r);
    drive(v.s);
    chk("busy_in_scan", int'(busy), 1);
    wait_valid(lat);
    chk("latency", lat, 10);
    @(posedge clk); #1;
    chk("valid_one_cycle", int'(result_valid), 0);
    chk("busy_after_handshake", int'(busy), 0);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v;
    res_t e;
    int lat;
    tbl[0] = '{s: '{3, 9, 1, 7, 0, 0, 0, 0, 0, 2}, r: '{idx: 1, top: 9, mar: 2, tie: 0}};
    tbl[1] = '{s: '{5, 200, 0, 0, 200, 0, 0, 0, 0, 0}, r: '{idx: 1, top: 200, mar: 0, tie: 1}};
    tbl[2] = '{s: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, r: '{idx: 0, top: 0, mar: 0, tie: 1}};
    tbl[3] = '{s: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 250}, r: '{idx: 9, top: 250, mar: 241, tie: 0}};
    for (int k = 4; k < 8; k++) begin
      for (int i = 0; i < 10; i++) tbl[k].s[i] = 8'($urandom_range(0, k < 6 ? 15 : 255));
      tbl[k].r = model(tbl[k].s);
    end
    for (int i = 0; i < 10; i++) scores[i] = 8'd77;
    scores1[0] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_fields", int'({class_idx, top_score, margin, tie}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_full(tbl[k]);

    // backpressure: outputs frozen, start and score changes ignored while held
    result_ready = 1'b0;
    v.s = '{10, 40, 30, 40, 12, 0, 39, 5, 5, 1};
    e = model(v.s);
    exp_q.push_back(e);
    drive(v.s);
    wait_valid(lat);
    chk("bp_latency", lat, 10);
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 10; i++) scores[i] = 8'($urandom_range(0, 255));
      start = j == 5;
      chk("bp_valid", int'(result_valid), 1);
      chk("bp_fields", int'({class_idx, top_score, margin, tie}), int'({e.idx, e.top, e.mar, e.tie}));
      @(posedge clk); #1;
      start = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", int'(result_valid), 0);
    chk("bp_done_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("bp_start_ignored", int'(busy), 0);

    // snapshot isolation: live scores churn during the scan
    v.s = '{100, 3, 180, 180, 7, 0, 99, 179, 1, 2};
    exp_q.push_back(model(v.s));
    drive(v.s);
    lat = 41;
    for (int c = 1; c <= 40; c++) begin
      for (int i = 0; i < 10; i++) scores[i] = 8'($urandom_range(200, 255));
      @(posedge clk); #1;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    chk("snap_latency", lat, 10);
    @(posedge clk); #1;

    // reset mid-scan: no result may appear
    v.s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    drive(v.s);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_fields", int'({result_valid, class_idx, top_score, margin, tie}), 0);
    lat = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (result_valid) lat = 1;
    end
    chk("abort_no_valid", lat, 0);
    v.s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
    v.r = '{idx: 9, top: 255, mar: 255, tie: 0};
    run_full(v);

    // single-class build
    scores1[0] = 8'd42;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("n1_busy", int'(busy1), 1);
    @(posedge clk); #1;
    chk("n1_valid_latency", int'(result_valid1), 1);
    chk("n1_class_idx", int'(class_idx1), 0);
    chk("n1_top_score", int'(top_score1), 42);
    chk("n1_margin", int'(margin1), 42);
    chk("n1_tie", int'(tie1), 0);
    @(posedge clk); #1;
    chk("n1_done", int'({result_valid1, busy1}), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_argmax_scanner.md
Name: output_argmax_scanner

Overview:
- Sequential classifier back-end attached to the output array of the feed-forward network, which produces 10 unsigned 8-bit scores.
- On a start pulse it snapshots all class scores, then scans one class per cycle.
- It tracks the best and second-best score and presents the winning digit, its score, the top-1/top-2 margin and a tie flag through a valid/ready handshake.
- The result feeds the board display/UART reporting logic.

Parameters:
- N_CLASSES, 10, number of output neurons scanned (must be >= 1).
- SCORE_W, 8, width of each unsigned score.
- IDX_W, $clog2(N_CLASSES) (minimum 1), width of the class index. Localparam derived from N_CLASSES; not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a classification. Sampled only in IDLE.
- scores  in  SCORE_W x N_CLASSES (unpacked array)  network output scores, unsigned.
- busy  out  1  high in SCAN and HOLD.
- result_valid  out  1  result fields valid (HOLD state).
- result_ready  in  1  consumer accepts the result.
- class_idx  out  IDX_W  index of the highest score.
- top_score  out  SCORE_W  highest score.
- margin  out  SCORE_W  top_score minus second-best score.
- tie  out  1  high when margin == 0 and N_CLASSES > 1.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, result_valid, class_idx, top_score, margin and tie are all 0.
  - The internal snapshot, index counter, best and second registers are cleared.
- Reset takes priority over every other input. Asserting rst during SCAN or HOLD aborts the operation; no result is ever presented for an aborted scan.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - If start = 1 at a clock edge: capture all scores into the snapshot registers, clear the counter, clear best/second, go to SCAN.
  - The live scores input is ignored after the capture edge.
- SCAN processes snapshot[i], one per cycle, with i running from 0 to N_CLASSES-1:
  - i == 0: best = s, best_idx = 0, second = 0.
  - s > best: second = best, best = s, best_idx = i.
  - Else if s > second: second = s.
  - Comparisons are strict, so on equal scores the lowest index wins.
  - After processing i = N_CLASSES-1: register the outputs (class_idx = best_idx, top_score = best, margin = best - second, tie) and go to HOLD.
  - The counter does not wrap; the transition to HOLD occurs exactly at N_CLASSES-1.
- Latency: start is sampled at edge k, and result_valid rises after edge k+N_CLASSES. With default parameters, result_valid rises 10 cycles after the start edge.
- HOLD:
  - result_valid = 1; all result fields stay stable until the handshake completes.
  - When result_valid and result_ready are both 1 at an edge: go to IDLE; result_valid and busy fall after that edge.
  - Result fields keep their last values in IDLE; they are only meaningful while result_valid = 1.
- start is ignored in SCAN and HOLD, including the cycle in which the handshake completes. The consumer must re-assert start in IDLE.
- result_ready is ignored outside HOLD.
- Arithmetic:
  - All comparisons are unsigned.
  - margin cannot underflow because second <= best always holds.
  - With N_CLASSES == 1: margin = top_score and tie = 0.
  - All-zero scores give class_idx = 0, margin = 0, tie = 1.

Decomposition:
- Shared package nn_pkg holds:
  - N_CLASSES and SCORE_W constants, matching the network's output layer width and neuron output width.
  - The typedef enum for the scanner states: IDLE, SCAN, HOLD.
  - A score_t typedef of logic [SCORE_W-1:0].
- One sub-module, argmax_step:
  - Purely combinational top-2 update cell.
  - Inputs: best, second, best_idx, score, index, first flag.
  - Outputs: updated best, second and best_idx.
  - The scanner instantiates it once inside the SCAN datapath.

Test Plan:
- scores = {3,9,1,7,0,0,0,0,0,2}, start pulse, result_ready held at 1:
  - result_valid rises 10 cycles after start.
  - Required result: class_idx = 1, top_score = 9, margin = 2, tie = 0.
  - result_valid is high for exactly one cycle.
- Tie case, scores = {5,200,0,0,200,0,0,0,0,0}:
  - class_idx = 1, top_score = 200, margin = 0, tie = 1.
- Backpressure:
  - Hold result_ready = 0 for 20 cycles after result_valid rises.
  - Change scores and pulse start during the hold.
  - Required: outputs stay constant and start is ignored.
  - Raising result_ready completes the handshake, and busy = 0 the next cycle.
- Snapshot isolation:
  - Change scores every cycle during SCAN.
  - Required: the result matches the values captured at the start edge.
- Reset mid-scan:
  - Assert rst 4 cycles into SCAN.
  - Required: all outputs 0, result_valid never rises.
  - A following start gives a correct result for new scores {0,0,0,0,0,0,0,0,0,255}: class_idx = 9, top_score = 255, margin = 255.
- Edge values:
  - All-zero scores: class_idx = 0, margin = 0, tie = 1.
  - Build with N_CLASSES = 1 and scores = {42}: class_idx = 0, margin = 42, tie = 0, latency 1 cycle.
